// File: rtl/calc_seq.sv
// Three-digit BCD two-operand adder front end: key entry, adder handshake with timeout, display drive.
// Define CALC_SEQ_BLANK_EN to blank leading zero digits on the display; otherwise disp_blank is 4'b0000.
module calc_seq #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        sum_ack,
    input  logic [15:0] sum_in,
    output logic [11:0] op_a,
    output logic [11:0] op_b,
    output logic        sum_req,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_blank,
    output logic [3:0]  led
);

    typedef enum logic [3:0] {
        ENTER_A = 4'b0001,
        ENTER_B = 4'b0010,
        CALC    = 4'b0100,
        SHOW    = 4'b1000
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_reg;
    logic [11:0] op_a_reg;
    logic [11:0] op_b_reg;
    logic [15:0] result_reg;
    logic        err_reg;
    logic        sum_req_reg;
    logic [7:0]  tcnt_reg;
    logic [15:0] disp_reg;
    logic [3:0]  led_reg;
    logic [15:0] disp_next;

    logic key_digit;
    logic key_next;
    logic key_equals;
    logic key_clear;

    assign key_digit  = key_valid && (key_code <= 4'd9);
    assign key_next   = key_valid && (key_code == 4'hA);
    assign key_equals = key_valid && (key_code == 4'hB);
    assign key_clear  = key_valid && (key_code == 4'hC);

    // Display follows the registered state, so it lags the state change by one cycle.
    always_comb begin
        disp_next = 16'h0000;
        case (state_reg)
            ENTER_A:       disp_next = {4'h0, op_a_reg};
            ENTER_B, CALC: disp_next = {4'h0, op_b_reg};
            SHOW:          disp_next = err_reg ? 16'hEEEE : result_reg;
            default:       disp_next = 16'h0000;
        endcase
    end

`ifdef CALC_SEQ_BLANK_EN
    logic [3:0] zero_nib;
    logic [3:0] blank_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero
            assign zero_nib[gi] = (disp_next[4*gi +: 4] == 4'h0);
        end
    endgenerate

    // Digit 0 is never blanked so a zero value still shows one digit.
    always_ff @(posedge clk) begin
        if (!n_reset)
            blank_reg <= 4'b1110;
        else
            blank_reg <= {zero_nib[3],
                          zero_nib[3] & zero_nib[2],
                          zero_nib[3] & zero_nib[2] & zero_nib[1],
                          1'b0};
    end

    assign disp_blank = blank_reg;
`else
    assign disp_blank = 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg   <= ENTER_A;
            op_a_reg    <= 12'h000;
            op_b_reg    <= 12'h000;
            result_reg  <= 16'h0000;
            err_reg     <= 1'b0;
            sum_req_reg <= 1'b0;
            tcnt_reg    <= 8'd0;
            disp_reg    <= 16'h0000;
            led_reg     <= 4'b0001;
        end else begin
            disp_reg <= disp_next;
            led_reg  <= state_reg;
            // Clear outranks everything, including a simultaneous adder ack.
            if (key_clear) begin
                state_reg   <= ENTER_A;
                op_a_reg    <= 12'h000;
                op_b_reg    <= 12'h000;
                err_reg     <= 1'b0;
                sum_req_reg <= 1'b0;
                tcnt_reg    <= 8'd0;
            end else begin
                case (state_reg)
                    ENTER_A: begin
                        if (key_digit && (op_a_reg[11:8] == 4'h0)) begin
                            op_a_reg <= {op_a_reg[7:0], key_code};
                        end else if (key_next) begin
                            state_reg <= ENTER_B;
                            op_b_reg  <= 12'h000;
                        end else if (key_equals) begin
                            state_reg   <= CALC;
                            sum_req_reg <= 1'b1;
                            tcnt_reg    <= 8'd0;
                        end
                    end
                    ENTER_B: begin
                        if (key_digit && (op_b_reg[11:8] == 4'h0)) begin
                            op_b_reg <= {op_b_reg[7:0], key_code};
                        end else if (key_equals) begin
                            state_reg   <= CALC;
                            sum_req_reg <= 1'b1;
                            tcnt_reg    <= 8'd0;
                        end
                    end
                    CALC: begin
                        if (sum_ack) begin
                            result_reg  <= sum_in;
                            sum_req_reg <= 1'b0;
                            state_reg   <= SHOW;
                        end else if (tcnt_reg == TMO_LAST) begin
                            sum_req_reg <= 1'b0;
                            err_reg     <= 1'b1;
                            state_reg   <= SHOW;
                        end else begin
                            tcnt_reg <= tcnt_reg + 8'd1;
                        end
                    end
                    SHOW: begin
                    end
                    default: state_reg <= ENTER_A;
                endcase
            end
        end
    end

    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign sum_req  = sum_req_reg;
    assign disp_bcd = disp_reg;
    assign led      = led_reg;

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq: display updates and sum_req pulse lengths are checked by monitors
// against expectations queued by the directed stimulus.
module tb_calc_seq;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        sum_ack = 1'b0;
    logic [15:0] sum_in = 16'h0000;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        sum_req;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_blank;
    logic [3:0]  led;

    calc_seq #(.ACK_TIMEOUT(255)) dut (
        .clk(clk), .n_reset(n_reset), .key_valid(key_valid), .key_code(key_code),
        .sum_ack(sum_ack), .sum_in(sum_in), .op_a(op_a), .op_b(op_b), .sum_req(sum_req),
        .disp_bcd(disp_bcd), .disp_blank(disp_blank), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  led;
        logic [15:0] disp;
        logic [3:0]  blank;
        logic [11:0] a;
        logic [11:0] b;
    } obs_t;

    obs_t exp_q[$];
    int   dur_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Adder model controls
    int          ack_at = 0;
    logic [15:0] ack_val = 16'h0000;
    bit          stray_ack = 1'b0;
    int          hi_cnt = 0;

    function automatic logic [3:0] bl(input logic [3:0] x);
`ifdef CALC_SEQ_BLANK_EN
        return x;
`else
        return 4'b0000 & x;
`endif
    endfunction

    task automatic expect_out(input logic [3:0] l, input logic [15:0] d, input logic [3:0] bk,
                              input logic [11:0] a, input logic [11:0] b);
        exp_q.push_back({l, d, bk, a, b});
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else
            $display("ok   %s = %h", name, got);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        idle(3);
    endtask

    // Adder: acks on the ack_at-th cycle of a sum_req pulse; stray_ack injects an unsolicited ack.
    always @(negedge clk) begin
        if (sum_req === 1'b1) hi_cnt++;
        else hi_cnt = 0;
        sum_ack = ((sum_req === 1'b1) && (ack_at != 0) && (hi_cnt == ack_at)) || stray_ack;
        sum_in  = ack_val;
    end

    // Display monitor: every change of led/disp/blank is one output transaction.
    obs_t cur, prev, e;
    always @(negedge clk) begin
        cur = {led, disp_bcd, disp_blank, op_a, op_b};
        if (mon_en && ({cur.led, cur.disp, cur.blank} !== {prev.led, prev.disp, prev.blank})) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL disp_event unexpected got led=%b disp=%h blank=%b a=%h b=%h",
                         cur.led, cur.disp, cur.blank, cur.a, cur.b);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL disp_event got led=%b disp=%h blank=%b a=%h b=%h want led=%b disp=%h blank=%b a=%h b=%h",
                             cur.led, cur.disp, cur.blank, cur.a, cur.b, e.led, e.disp, e.blank, e.a, e.b);
                end else
                    $display("ok   disp_event led=%b disp=%h blank=%b a=%h b=%h",
                             cur.led, cur.disp, cur.blank, cur.a, cur.b);
            end
        end
        prev = cur;
    end

    // Handshake monitor: length of each sum_req pulse in cycles.
    int req_cnt = 0;
    int want_dur;
    always @(negedge clk) begin
        if (sum_req === 1'b1) req_cnt++;
        else begin
            if (req_cnt > 0) begin
                checks++;
                if (dur_q.size() == 0) begin
                    errors++;
                    $display("FAIL sum_req_pulse unexpected got=%0d cycles", req_cnt);
                end else begin
                    want_dur = dur_q.pop_front();
                    if (req_cnt != want_dur) begin
                        errors++;
                        $display("FAIL sum_req_pulse got=%0d want=%0d cycles", req_cnt, want_dur);
                    end else
                        $display("ok   sum_req_pulse %0d cycles", req_cnt);
                end
            end
            req_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // Reset values
        idle(2);
        chk("rst_op_a", {4'h0, op_a}, 16'h0000);
        chk("rst_op_b", {4'h0, op_b}, 16'h0000);
        chk("rst_sum_req", {15'h0, sum_req}, 16'h0000);
        chk("rst_disp", disp_bcd, 16'h0000);
        chk("rst_blank", {12'h0, disp_blank}, {12'h0, bl(4'b1110)});
        chk("rst_led", {12'h0, led}, 16'h0001);
        n_reset = 1'b1;
        idle(2);
        mon_en = 1'b1;

        // 123 + 045, adder acks on third cycle
        ack_at = 3; ack_val = 16'h0168;
        expect_out(4'b0001, 16'h0001, bl(4'b1110), 12'h001, 12'h000); press(4'h1);
        expect_out(4'b0001, 16'h0012, bl(4'b1100), 12'h012, 12'h000); press(4'h2);
        expect_out(4'b0001, 16'h0123, bl(4'b1000), 12'h123, 12'h000); press(4'h3);
        expect_out(4'b0010, 16'h0000, bl(4'b1110), 12'h123, 12'h000); press(4'hA);
        expect_out(4'b0010, 16'h0004, bl(4'b1110), 12'h123, 12'h004); press(4'h4);
        expect_out(4'b0010, 16'h0045, bl(4'b1100), 12'h123, 12'h045); press(4'h5);
        expect_out(4'b0100, 16'h0045, bl(4'b1100), 12'h123, 12'h045);
        expect_out(4'b1000, 16'h0168, bl(4'b1000), 12'h123, 12'h045);
        dur_q.push_back(3);
        press(4'hB);
        idle(5);
        press(4'h1);
        expect_out(4'b0001, 16'h0000, bl(4'b1110), 12'h000, 12'h000); press(4'hC);

        // Fourth digit is dropped once three are held
        ack_at = 0;
        expect_out(4'b0001, 16'h0009, bl(4'b1110), 12'h009, 12'h000); press(4'h9);
        expect_out(4'b0001, 16'h0099, bl(4'b1100), 12'h099, 12'h000); press(4'h9);
        expect_out(4'b0001, 16'h0999, bl(4'b1000), 12'h999, 12'h000); press(4'h9);
        press(4'h7);
        chk("op_a_full", {4'h0, op_a}, 16'h0999);
        expect_out(4'b0001, 16'h0000, bl(4'b1110), 12'h000, 12'h000); press(4'hC);

        // No ack: timeout after 255 cycles, error display
        expect_out(4'b0001, 16'h0005, bl(4'b1110), 12'h005, 12'h000); press(4'h5);
        expect_out(4'b0100, 16'h0000, bl(4'b1110), 12'h005, 12'h000);
        expect_out(4'b1000, 16'hEEEE, 4'b0000, 12'h005, 12'h000);
        dur_q.push_back(255);
        press(4'hB);
        idle(300);
        expect_out(4'b0001, 16'h0000, bl(4'b1110), 12'h000, 12'h000); press(4'hC);

        // Ack on the timeout cycle wins
        ack_at = 255; ack_val = 16'h0777;
        expect_out(4'b0001, 16'h0002, bl(4'b1110), 12'h002, 12'h000); press(4'h2);
        expect_out(4'b0100, 16'h0000, bl(4'b1110), 12'h002, 12'h000);
        expect_out(4'b1000, 16'h0777, bl(4'b1000), 12'h002, 12'h000);
        dur_q.push_back(255);
        press(4'hB);
        idle(300);
        expect_out(4'b0001, 16'h0000, bl(4'b1110), 12'h000, 12'h000); press(4'hC);

        // Clear in the same cycle as ack: back to ENTER_A, no SHOW
        ack_at = 2; ack_val = 16'h0555;
        expect_out(4'b0001, 16'h0003, bl(4'b1110), 12'h003, 12'h000); press(4'h3);
        expect_out(4'b0100, 16'h0000, bl(4'b1110), 12'h003, 12'h000);
        expect_out(4'b0001, 16'h0000, bl(4'b1110), 12'h000, 12'h000);
        dur_q.push_back(2);
        key_valid = 1'b1; key_code = 4'hB;
        @(posedge clk); #1;
        key_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (sum_ack) begin
                seen = 1'b1;
                key_valid = 1'b1; key_code = 4'hC;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_wait got=no_ack want=ack within 20 cycles");
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        idle(5);
        chk("clr_ack_led", {12'h0, led}, 16'h0001);
        ack_at = 0;

        // Reset mid-handshake, then a stray ack
        expect_out(4'b0001, 16'h0007, bl(4'b1110), 12'h007, 12'h000); press(4'h7);
        expect_out(4'b0100, 16'h0000, bl(4'b1110), 12'h007, 12'h000);
        expect_out(4'b0001, 16'h0000, bl(4'b1110), 12'h000, 12'h000);
        dur_q.push_back(4);
        press(4'hB);
        n_reset = 1'b0;
        @(posedge clk); #1;
        n_reset = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        idle(5);
        chk("post_rst_led", {12'h0, led}, 16'h0001);
        chk("post_rst_disp", disp_bcd, 16'h0000);
        chk("post_rst_req", {15'h0, sum_req}, 16'h0000);
        chk("post_rst_op_a", {4'h0, op_a}, 16'h0000);

        idle(5);
        checks++;
        if (exp_q.size() != 0 || dur_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got disp=%0d req=%0d want 0 pending", exp_q.size(), dur_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
